// File: rtl/gradient_calc.sv
// Central-difference gradient, L1 magnitude and orientation bin.
// Define HOG_SIGNED_ORIENT_EN for 18 signed bins (default: 9 unsigned).
module gradient_calc #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 638,
  parameter int IMAGE_HEIGHT = 478
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   magnitude,
  output logic [4:0]            bin
);

  localparam int D  = DATA_WIDTH;
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          en;
  logic          accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  logic [D-1:0] lb1 [IMAGE_WIDTH];
  logic [D-1:0] lb2 [IMAGE_WIDTH];
  logic [D-1:0] t0, t1;
  logic [D-1:0] m0, m1, m2;
  logic [D-1:0] b0, b1;
  logic         w_valid;

  // line buffers and 3x3 window shift on every accepted pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= pixel;
      t0 <= t1;
      t1 <= lb2[col];
      m0 <= m1;
      m1 <= m2;
      m2 <= lb1[col];
      b0 <= b1;
      b1 <= pixel;
    end
  end

  // raster counters and window-complete flag for interior centres
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      w_valid <= 1'b0;
    end else if (en) begin
      w_valid <= accept && (row >= RW'(2))
                        && (col >= CW'(2));
      if (accept) begin
        if (col == CW'(IMAGE_WIDTH - 1)) begin
          col <= '0;
          if (row == RW'(IMAGE_HEIGHT - 1))
            row <= '0;
          else
            row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  logic         s1_valid;
  logic [D-1:0] s1_l, s1_r, s1_u, s1_d;

  // S1: capture the four neighbours of the centre
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_l     <= '0;
      s1_r     <= '0;
      s1_u     <= '0;
      s1_d     <= '0;
    end else if (en) begin
      s1_valid <= w_valid;
      s1_l     <= m0;
      s1_r     <= m2;
      s1_u     <= t0;
      s1_d     <= b0;
    end
  end

  logic              s2_valid;
  logic signed [D:0] gx, gy;

  // S2: signed central differences
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      gx       <= '0;
      gy       <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      gx <= $signed({1'b0, s1_r}) - $signed({1'b0, s1_l});
      gy <= $signed({1'b0, s1_d}) - $signed({1'b0, s1_u});
    end
  end

  logic signed [D:0] fx, fy;
  logic        [D:0] ax, agx, agy, mag_n;
  logic       [31:0] lhs, axw;
  logic        [2:0] n;
  logic        [4:0] ub, bin_n;

  // fold to the upper half-plane and count tangent thresholds passed
  always_comb begin
    fx = gx;
    fy = gy;
    if (gy < 0) begin
      fx = -gx;
      fy = -gy;
    end
    ax  = (fx < 0) ? $unsigned(-fx) : $unsigned(fx);
    agx = (gx < 0) ? $unsigned(-gx) : $unsigned(gx);
    agy = (gy < 0) ? $unsigned(-gy) : $unsigned(gy);
    mag_n = agx + agy;
    lhs = 32'($unsigned(fy)) << 8;
    axw = 32'(ax);
    n = 3'd0;
    if (lhs >= 32'd93 * axw)   n = n + 3'd1;
    if (lhs >= 32'd215 * axw)  n = n + 3'd1;
    if (lhs >= 32'd443 * axw)  n = n + 3'd1;
    if (lhs >= 32'd1452 * axw) n = n + 3'd1;
    if (gy == 0)
      ub = 5'd0;
    else if (fx < 0)
      ub = 5'd8 - {2'b00, n};
    else
      ub = {2'b00, n};
`ifdef HOG_SIGNED_ORIENT_EN
    bin_n = ub;
    if ((gy < 0) || ((gy == 0) && (gx < 0)))
      bin_n = ub + 5'd9;
`else
    bin_n = ub;
`endif
  end

  // S3: output register, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      magnitude <= '0;
      bin       <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        magnitude <= mag_n;
        bin       <= bin_n;
      end
    end
  end

endmodule

// File: tb/tb_gradient_calc.sv
// Scoreboard bench for gradient_calc on an 8x6 image.
// Directed ramps, random stalls, mid-frame reset and back-to-back frames.
module tb_gradient_calc;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int NR = (W - 2) * (H - 2);
`ifdef HOG_SIGNED_ORIENT_EN
  localparam int DOWN_BIN = 13;
`else
  localparam int DOWN_BIN = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] pixel = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW:0]   magnitude;
  logic [4:0]    bin;

  gradient_calc #(
    .DATA_WIDTH  (DW),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pixel    (pixel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .magnitude(magnitude),
    .bin      (bin)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] m;
    logic [4:0] b;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   img [H][W];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   got = 0;
  int   first_cyc = -1;
  int   acc22 = -1;
  bit   rnd_ready = 0;
  bit   ignore = 0;
  bit   lat_arm = 0;
  logic       stall_prev = 1'b0;
  logic [8:0] hm;
  logic [4:0] hb;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // golden model of one result
  function automatic void model(input int gx, input int gy,
                                output int m, output int b);
    int x, y, ax, k;
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (gy == 0) begin
      k = 0;
    end else begin
      x = (gy < 0) ? -gx : gx;
      y = (gy < 0) ? -gy : gy;
      ax = (x < 0) ? -x : x;
      if      (256 * y < 93 * ax)   k = 0;
      else if (256 * y < 215 * ax)  k = 1;
      else if (256 * y < 443 * ax)  k = 2;
      else if (256 * y < 1452 * ax) k = 3;
      else                          k = 4;
      if (x < 0) k = 8 - k;
    end
    b = k;
`ifdef HOG_SIGNED_ORIENT_EN
    if (gy < 0 || (gy == 0 && gx < 0)) b = k + 9;
`endif
  endfunction

  function automatic void fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = 10 * c;
          1: img[r][c] = 10 * r;
          2: img[r][c] = 10 * (r + c);
          3: img[r][c] = 100 + 10 * (r - c);
          4: img[r][c] = 100 - 10 * r;
          5: img[r][c] = 77;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endfunction

  function automatic void push_const(input int m, input int b);
    for (int i = 0; i < NR; i++) q.push_back('{m: 9'(m), b: 5'(b)});
  endfunction

  function automatic void push_model();
    int m, b;
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        model(img[r][c+1] - img[r][c-1],
              img[r+1][c] - img[r-1][c], m, b);
        q.push_back('{m: 9'(m), b: 5'(b)});
      end
  endfunction

  // monitor: pops expected result on each output transfer
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_magnitude", magnitude, hm);
        check("hold_bin", bin, hb);
      end
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (lat_arm && out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && out_ready) begin
        got++;
        if (!ignore) begin
          if (q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = q.pop_front();
            check("magnitude", magnitude, e.m);
            check("bin", bin, e.b);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      hm = magnitude;
      hb = bin;
    end
  end

  // downstream ready: always on, or 50% random
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input int r, input int c, input bit gap);
    int g;
    if (gap)
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    pixel = DW'(img[r][c]);
    in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (lat_arm && r == 2 && c == 2) acc22 = cyc;
  endtask

  task automatic send_frame(input bit gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) send(r, c, gap);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input int n);
    int g;
    g = 0;
    while (q.size() > 0 && g < 1000) begin
      @(posedge clk);
      g++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({nm, "_queue_left"}, q.size(), 0);
    check({nm, "_count"}, got, n);
    q.delete();
    got = 0;
  endtask

  int dm[5] = '{20, 40, 40, 20, 0};
  int db[5] = '{4, 2, 6, DOWN_BIN, 0};

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_magnitude", magnitude, 0);
    check("reset_bin", bin, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    fill(0);
    push_const(20, 0);
    lat_arm = 1;
    send_frame(0);
    drain("hramp", NR);
    check("latency", first_cyc - acc22, 3);
    lat_arm = 0;

    for (int k = 0; k < 5; k++) begin
      fill(k + 1);
      push_const(dm[k], db[k]);
      send_frame(0);
      drain($sformatf("directed%0d", k + 1), NR);
    end

    rnd_ready = 1;
    for (int k = 0; k < 2; k++) begin
      fill(6);
      push_model();
      send_frame(1);
      drain($sformatf("random%0d", k), NR);
    end
    rnd_ready = 0;
    @(posedge clk);
    #1;

    ignore = 1;
    fill(5);
    for (int i = 0; i < 3 * W + 3; i++) send(i / W, i % W, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    ignore = 0;
    got = 0;
    fill(0);
    push_const(20, 0);
    send_frame(0);
    drain("after_reset", NR);

    fill(0);
    push_const(20, 0);
    send_frame(0);
    fill(2);
    push_const(40, 2);
    send_frame(0);
    drain("back_to_back", 2 * NR);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
